// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types and constants for the data-memory responder.
//               Provides the access FSM state encoding, the access-size
//               codes, the wait-state counter width and the helper that
//               turns a size/offset pair into a big-endian lane enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int CNT_W = 4;

    // Lane 3 holds the byte at offset 0 (bits [31:24]); big-endian ordering
    // means a byte at offset N enables lane 3-N.
    function automatic logic [3:0] lane_enable(input logic size, input logic [1:0] offset);
        logic [3:0] en;
        if (size == SIZE_WORD) begin
            en = 4'b1111;
        end else begin
            en = 4'b1000 >> offset;
        end
        return en;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_byte_array.sv
// ============================================================================
// Module      : dmem_byte_array
// Description : DEPTH-byte storage for the data-memory responder.
//               Four bytes starting at the aligned index are read
//               asynchronously and returned big-endian; writes are
//               synchronous with one enable per byte lane.
// Ports       : clk     - clock
//               idx_i   - byte index; low two bits and bits above the
//                         array size are ignored
//               be_i    - lane enables, [3] = offset 0 ... [0] = offset 3
//               wdata_i - write data, [31:24] = offset 0
//               rdata_o - read data, [31:24] = offset 0
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_byte_array #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic [7:0]  idx_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    base;
    logic [AW-1:0] lane_idx [4];

    // Aligned and wrapped into the array; base+3 can never leave it.
    assign base = idx_i & 8'(DEPTH - 4);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_idx[k] = base[AW-1:0] + AW'(k);
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int k = 0; k < 4; k++) begin
            rdata_o[31-8*k -: 8] = mem_q[lane_idx[k]];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (be_i[3-k]) begin
                mem_q[lane_idx[k]] <= wdata_i[31-8*k -: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
// Module      : data_mem_responder
// Description : MEM-stage data-memory responder. Accepts a load/store from
//               the EX/MEM register, holds the pipeline with stall while
//               WAIT_CYCLES wait states elapse, then completes in a DONE
//               cycle with done (and rdata_valid for loads). Byte and word
//               accesses, big-endian.
// Option      : DMEM_MISALIGN_CHECK_EN - when defined, word accesses with
//               addr[1:0] != 0 complete with err=1, no write, rdata=0.
//               When undefined, word addresses are forced aligned and err
//               is always 0.
// Ports       : clk, reset (async, active-high)
//               req_en/req_write/req_size/req_addr/req_wdata - request
//               stall       - pipeline hold (combinational)
//               rdata       - load data (registered, holds between loads)
//               rdata_valid - one-cycle load completion pulse
//               done        - one-cycle completion pulse for any access
//               err         - one-cycle misalignment pulse, with done
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_en,
    input  logic        req_write,
    input  logic        req_size,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        done,
    output logic        err
);

    dmem_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             wr_q;
    logic             size_q;
    logic [7:0]       addr_q;
    logic [31:0]      wdata_q;
    logic [31:0]      rdata_q;
    logic             rdata_valid_q;
    logic             done_q;
    logic             err_q;

    logic        acc_idle;
    logic        acc_write;
    logic        acc_size;
    logic [7:0]  acc_addr;
    logic        misalign;
    logic        enter_done;
    logic [31:0] arr_rdata;
    logic [31:0] arr_wdata;
    logic [3:0]  arr_be;
    logic [7:0]  load_byte;
    logic [31:0] load_data;

    // With zero wait states DONE is entered straight from IDLE, before the
    // request has been latched, so the access fields come from the inputs.
    assign acc_idle  = (state_q == IDLE);
    assign acc_write = acc_idle ? req_write : wr_q;
    assign acc_size  = acc_idle ? req_size  : size_q;
    assign acc_addr  = acc_idle ? req_addr  : addr_q;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = (acc_size == SIZE_WORD) && (acc_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign enter_done = (acc_idle && req_en && (WAIT_CYCLES == 0))
                     || ((state_q == WAIT) && (cnt_q <= CNT_W'(1)));

    dmem_byte_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .idx_i   (acc_addr),
        .be_i    (arr_be),
        .wdata_i (arr_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        load_byte = 8'h00;
        case (acc_addr[1:0])
            2'd0:    load_byte = arr_rdata[31:24];
            2'd1:    load_byte = arr_rdata[23:16];
            2'd2:    load_byte = arr_rdata[15:8];
            default: load_byte = arr_rdata[7:0];
        endcase
    end

    assign load_data = misalign                 ? 32'h0     :
                       (acc_size == SIZE_WORD)  ? arr_rdata :
                                                  {24'h0, load_byte};

    // Store commits on the DONE->IDLE edge. err_q blocks misaligned words;
    // the reset term keeps an abandoned store from landing on the same edge.
    assign arr_be    = ((state_q == DONE) && wr_q && !err_q && !reset)
                     ? lane_enable(size_q, addr_q[1:0]) : 4'b0000;
    assign arr_wdata = (size_q == SIZE_WORD) ? wdata_q : {4{wdata_q[7:0]}};

    assign stall = !reset && ((acc_idle && req_en) || (state_q == WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            wr_q          <= 1'b0;
            size_q        <= SIZE_BYTE;
            addr_q        <= 8'h00;
            wdata_q       <= 32'h0;
            rdata_q       <= 32'h0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (req_en) begin
                        wr_q    <= req_write;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // req_en here still belongs to the completing access.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            if (enter_done) begin
                done_q <= 1'b1;
                err_q  <= misalign;
                if (!acc_write) begin
                    rdata_valid_q <= 1'b1;
                    rdata_q       <= load_data;
                end
            end
        end
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Two instances
//               run side by side: WAIT_CYCLES=2 (index 0) and WAIT_CYCLES=0
//               (index 1). A byte-array model per instance predicts load
//               data, latency, err and rdata hold behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int DEPTH = 256;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       req_en = '0;
    logic [1:0]       req_write = '0;
    logic [1:0]       req_size = '0;
    logic [1:0][7:0]  req_addr = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       stall;
    logic [1:0][31:0] rdata;
    logic [1:0]       rdata_valid;
    logic [1:0]       done;
    logic [1:0]       err;

    logic [7:0]  mdl [2][DEPTH];
    logic [31:0] mrd [2];
    int          wc  [2];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk         (clk),
        .reset       (reset),
        .req_en      (req_en[0]),
        .req_write   (req_write[0]),
        .req_size    (req_size[0]),
        .req_addr    (req_addr[0]),
        .req_wdata   (req_wdata[0]),
        .stall       (stall[0]),
        .rdata       (rdata[0]),
        .rdata_valid (rdata_valid[0]),
        .done        (done[0]),
        .err         (err[0])
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk         (clk),
        .reset       (reset),
        .req_en      (req_en[1]),
        .req_write   (req_write[1]),
        .req_size    (req_size[1]),
        .req_addr    (req_addr[1]),
        .req_wdata   (req_wdata[1]),
        .stall       (stall[1]),
        .rdata       (rdata[1]),
        .rdata_valid (rdata_valid[1]),
        .done        (done[1]),
        .err         (err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input int d, input string tag);
        check($sformatf("%s_stall%0d", tag, d), 32'(stall[d]), 32'h0);
        check($sformatf("%s_done%0d", tag, d), 32'(done[d]), 32'h0);
        check($sformatf("%s_rvalid%0d", tag, d), 32'(rdata_valid[d]), 32'h0);
        check($sformatf("%s_err%0d", tag, d), 32'(err[d]), 32'h0);
        check($sformatf("%s_rdata%0d", tag, d), rdata[d], 32'h0);
    endtask

    // One complete access on instance d. Returns during the DONE cycle,
    // #1 after the negedge; req_en is left high when hold is set.
    task automatic access(input int d, input logic wr, input logic sz,
                          input logic [7:0] a, input logic [31:0] wd, input logic hold);
        logic [7:0]  base;
        logic [31:0] word;
        logic [31:0] exp_rd;
        logic        exp_err;
        int          n;
        logic        got;

        base    = a & 8'hFC;
        exp_err = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
        exp_err = sz && (a[1:0] != 2'b00);
`endif
        word = {mdl[d][base], mdl[d][base + 8'd1], mdl[d][base + 8'd2], mdl[d][base + 8'd3]};
        exp_rd = mrd[d];
        if (!wr) begin
            exp_rd = exp_err ? 32'h0 : (sz ? word : {24'h0, mdl[d][a]});
        end

        @(negedge clk);
        req_en[d]    = 1'b1;
        req_write[d] = wr;
        req_size[d]  = sz;
        req_addr[d]  = a;
        req_wdata[d] = wd;

        n   = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            #1;
            if (done[d]) begin
                got = 1'b1;
            end else begin
                if (stall[d]) n++;
                @(negedge clk);
            end
        end

        check($sformatf("d%0d_done_seen", d), 32'(got), 32'h1);
        check($sformatf("d%0d_stall_cycles", d), 32'(n), 32'(wc[d] + 1));
        check($sformatf("d%0d_stall_in_done", d), 32'(stall[d]), 32'h0);
        check($sformatf("d%0d_err", d), 32'(err[d]), 32'(exp_err));
        check($sformatf("d%0d_rvalid", d), 32'(rdata_valid[d]), 32'(!wr));
        mrd[d] = exp_rd;
        check($sformatf("d%0d_rdata_%02h", d, a), rdata[d], mrd[d]);

        if (wr && !exp_err) begin
            if (sz) begin
                for (int k = 0; k < 4; k++) begin
                    mdl[d][base + 8'(k)] = wd[31-8*k -: 8];
                end
            end else begin
                mdl[d][a] = wd[7:0];
            end
        end
        if (!hold) req_en[d] = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        wc[0]  = 2;
        wc[1]  = 0;
        mrd[0] = 32'h0;
        mrd[1] = 32'h0;

        // Reset state, with a request pending to prove stall is held low.
        reset     = 1'b1;
        req_en[0] = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_idle_outputs(d, "reset");
        req_en[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Give every byte a known value.
        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < DEPTH / 4; w++) begin
                access(d, 1'b1, 1'b1, 8'(w * 4), $urandom, 1'b0);
            end
        end

        // Word store then byte/word loads, back to back.
        access(0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
        access(0, 1'b0, 1'b0, 8'h11, 32'h0, 1'b0);
        check("tp_byte_11", rdata[0], 32'h000000AD);
        access(0, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
        check("tp_word_10", rdata[0], 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 8'h12, 32'hFFFFFF55, 1'b0);
        check("tp_store_keeps_rdata", rdata[0], 32'hDEADBEEF);
        access(0, 1'b0, 1'b1, 8'h10, 32'h0, 1'b0);
        check("tp_word_after_byte", rdata[0], 32'hDEAD55EF);
        @(negedge clk);
        #1;
        check("tp_done_one_cycle", 32'(done[0]), 32'h0);
        check("tp_rvalid_one_cycle", 32'(rdata_valid[0]), 32'h0);
        check("tp_rdata_holds", rdata[0], 32'hDEAD55EF);

        // Zero wait states; req_en held through DONE must not re-trigger.
        access(1, 1'b1, 1'b1, 8'h40, 32'hA5A55A5A, 1'b0);
        access(1, 1'b0, 1'b1, 8'h40, 32'h0, 1'b1);
        check("w0_word_40", rdata[1], 32'hA5A55A5A);
        @(negedge clk);
        req_en[1] = 1'b0;
        #1;
        check("w0_hold_no_done", 32'(done[1]), 32'h0);
        check("w0_hold_no_stall", 32'(stall[1]), 32'h0);
        @(negedge clk);
        #1;
        check("w0_hold_no_done2", 32'(done[1]), 32'h0);

        // Reset during WAIT of a store: nothing written, outputs cleared.
        @(negedge clk);
        req_en[0]    = 1'b1;
        req_write[0] = 1'b1;
        req_size[0]  = 1'b1;
        req_addr[0]  = 8'h20;
        req_wdata[0] = 32'h12345678;
        @(negedge clk);
        #1;
        check("rst_pre_stall", 32'(stall[0]), 32'h1);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) check_idle_outputs(d, "rst_mid");
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_idle_outputs(d, "rst_held");
        req_en[0] = 1'b0;
        reset     = 1'b0;
        mrd[0]    = 32'h0;
        mrd[1]    = 32'h0;
        access(0, 1'b0, 1'b1, 8'h20, 32'h0, 1'b0);
        access(1, 1'b0, 1'b1, 8'h40, 32'h0, 1'b0);

        // Misaligned word at 0x22.
        access(0, 1'b1, 1'b1, 8'h22, 32'hCAFEF00D, 1'b0);
        access(0, 1'b0, 1'b1, 8'h22, 32'h0, 1'b0);
        access(0, 1'b0, 1'b1, 8'h20, 32'h0, 1'b0);

        // Random traffic on both instances.
        repeat (200) begin
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 8'($urandom), $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
